// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial 16-bit adder: one shared 4-bit ripple-carry adder (R_4bit) walked over four nibbles, LSB first.
// Optional subtract mode is enabled by defining NIBBLE_SERIAL_SUB_EN, which adds the 'sub' input port.

module R_4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c,
  output logic [3:0] o_s,
  output logic       o_c
);

  logic w_c1;
  logic w_c2;
  logic w_c3;
  logic w_s0;
  logic w_s1;
  logic w_s2;
  logic w_s3;

  // Plain ripple chain of four full adders.
  assign w_s0 = i_a[0] ^ i_b[0] ^ i_c;
  assign w_c1 = (i_a[0] & i_b[0]) | (i_c  & (i_a[0] ^ i_b[0]));
  assign w_s1 = i_a[1] ^ i_b[1] ^ w_c1;
  assign w_c2 = (i_a[1] & i_b[1]) | (w_c1 & (i_a[1] ^ i_b[1]));
  assign w_s2 = i_a[2] ^ i_b[2] ^ w_c2;
  assign w_c3 = (i_a[2] & i_b[2]) | (w_c2 & (i_a[2] ^ i_b[2]));
  assign w_s3 = i_a[3] ^ i_b[3] ^ w_c3;
  assign o_c  = (i_a[3] & i_b[3]) | (w_c3 & (i_a[3] ^ i_b[3]));
  assign o_s  = {w_s3, w_s2, w_s1, w_s0};

endmodule

module nibble_serial_add_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
`ifdef NIBBLE_SERIAL_SUB_EN
  input  logic        sub,
`endif
  output logic        busy,
  output logic        done,
  output logic [15:0] sum,
  output logic        cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic        r_carry;
  logic [1:0]  r_idx;
  logic [15:0] r_sum;
  logic        r_cout;
  logic        r_busy;
  logic        r_done;

  logic [3:0]  w_aNib;
  logic [3:0]  w_bRaw;
  logic [3:0]  w_bNib;
  logic [3:0]  w_nibSum;
  logic        w_nibCarry;
  logic        w_startCarry;

  assign w_aNib = r_a[{r_idx, 2'b00} +: 4];
  assign w_bRaw = r_b[{r_idx, 2'b00} +: 4];

`ifdef NIBBLE_SERIAL_SUB_EN
  logic r_sub;

  // Subtraction is a + ~b + 1: invert b per nibble and seed the chain with 1.
  assign w_bNib       = r_sub ? ~w_bRaw : w_bRaw;
  assign w_startCarry = sub ? 1'b1 : cin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sub <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_sub <= sub;
    end
  end
`else
  assign w_bNib       = w_bRaw;
  assign w_startCarry = cin;
`endif

  R_4bit u_adder (
    .i_a (w_aNib),
    .i_b (w_bNib),
    .i_c (r_carry),
    .o_s (w_nibSum),
    .o_c (w_nibCarry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= 16'h0000;
      r_b     <= 16'h0000;
      r_carry <= 1'b0;
      r_idx   <= 2'd0;
      r_sum   <= 16'h0000;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RUN;
            r_a     <= a;
            r_b     <= b;
            r_carry <= w_startCarry;
            r_idx   <= 2'd0;
            r_sum   <= 16'h0000;
            r_cout  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          r_sum[{r_idx, 2'b00} +: 4] <= w_nibSum;
          r_carry                    <= w_nibCarry;
          r_idx                      <= r_idx + 2'd1;
          // The last nibble's carry-out is the overall carry.
          if (r_idx == 2'd3) begin
            r_cout  <= w_nibCarry;
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: doc/nibble_serial_add_ctrl.md
NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  request to begin a 16-bit addition; sampled only in IDLE.
REQ-005 a  in  16  operand A; captured on the accepting edge.
REQ-006 b  in  16  operand B; captured on the accepting edge.
REQ-007 cin  in  1  carry-in to nibble 0; captured on the accepting edge.
REQ-008 busy  out  1  high while nibble additions are in progress (RUN).
REQ-009 done  out  1  one-cycle pulse when the result is complete (DONE).
REQ-010 sum  out  16  result register.
REQ-011 cout  out  1  final carry-out of nibble 3.

Function
REQ-012 The block SHALL compute a+b+cin using exactly one instance of the team's 4-bit ripple-carry adder (R_4bit), time-shared over 4 nibbles, LSB nibble first.
REQ-013 FSM states SHALL be IDLE, RUN and DONE. IDLE -> RUN on start=1. RUN -> RUN while the nibble index is 0..2. RUN -> DONE after nibble 3. DONE -> IDLE unconditionally.
REQ-014 On the accepting edge (E0), the block SHALL latch a, b and cin, clear the nibble index to 0, and clear sum and cout to 0.
REQ-015 On each RUN edge (E1..E4), the block SHALL drive the adder with a[4i+3:4i], b[4i+3:4i] and the carry register, write the adder sum into sum[4i+3:4i], load the carry register from the adder carry-out, and increment i.
REQ-016 cout SHALL be loaded with the nibble-3 carry-out at E4.
REQ-017 Latency: busy=1 in the cycles after E0..E3; done=1 for exactly the one cycle after E4; the FSM is back in IDLE after E5.
REQ-018 start SHALL be ignored in RUN and DONE. A start asserted in the DONE cycle is not accepted. A start held high is accepted on the first IDLE edge.
REQ-019 Changes to a, b and cin after E0 SHALL NOT affect the result in progress.
REQ-020 sum and cout SHALL hold their values after done until the next accepted start.
REQ-021 The carry SHALL propagate across nibble boundaries with no loss. A 16-bit overflow SHALL appear only on cout; sum wraps modulo 2^16.
REQ-022 busy and done SHALL never be high in the same cycle.

Reset
REQ-023 On rst=1, at any time including mid-RUN, the block SHALL immediately force: state IDLE, nibble index 0, carry register 0, sum 0x0000, cout 0, busy 0, done 0.
REQ-024 After rst is released, the first rising clk edge with start=1 SHALL be accepted.
REQ-025 An operation interrupted by reset SHALL be discarded; there is no resumption.

Configuration
REQ-026 Macro NIBBLE_SERIAL_SUB_EN SHALL control the subtract feature.
- When defined: the block adds input port sub (in, 1), captured at E0. When the captured sub=1, each b nibble is inverted before the adder, the initial carry is forced to 1 and cin is ignored, so sum = a-b mod 2^16 and cout=1 means no borrow.
- When undefined: the sub port does not exist and the block performs addition only.

Verification
REQ-027 The bench SHALL cover the following directed scenarios:
- a=0x1234, b=0x4321, cin=0, start pulse -> busy for 4 cycles, done pulse in the 5th cycle, sum=0x5555, cout=0.
- a=0xFFFF, b=0x0001, cin=0 -> carry ripples through all nibbles; sum=0x0000, cout=1.
- a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0.
- Start accepted with a=0x00F0, b=0x0010; in the following cycle assert start again with a=0xAAAA -> second start ignored; sum=0x0100; start held high through DONE is accepted only on the next IDLE edge.
- Operands 0x8888+0x8888; assert rst after E2 -> sum=0x0000, cout=0, busy=0, done=0 at once; a new start after release gives sum=0x1110, cout=1.
- NIBBLE_SERIAL_SUB_EN defined: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0. Then a=0x0007, b=0x0005, sub=1 -> sum=0x0002, cout=1.
